lsu_io_responder: RTL and testbench

//  Memory-side responder for the single-cycle core's load/store port.

---
 rtl/lsu_io_if.sv | 23 ++
 rtl/lsu_io_responder.sv | 181 ++++++++++++++++++
 tb/tb_lsu_io_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_io_if.sv
// Load/store request/response channel between the core's LSU and its memory/IO responder.
interface lsu_io_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/lsu_io_responder.sv
// Far end of the LSU port: data memory plus LED/HEX/switch registers, one request
// at a time, response after a fixed wait.
module lsu_io_responder #(
    parameter int DMEM_WORDS  = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    lsu_io_if.slave     bus,
    input  logic [31:0] io_sw_i,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_ledg_o,
    output logic [6:0]  io_hex0_o,
    output logic [6:0]  io_hex1_o,
    output logic [6:0]  io_hex2_o,
    output logic [6:0]  io_hex3_o,
    output logic [6:0]  io_hex4_o,
    output logic [6:0]  io_hex5_o,
    output logic [6:0]  io_hex6_o,
    output logic [6:0]  io_hex7_o
);
    localparam int          IDXW      = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
    localparam logic [31:0] DMEM_END  = DMEM_BASE + 32'(4 * DMEM_WORDS);
    localparam logic [31:0] LEDR_ADDR = 32'h0000_7000;
    localparam logic [31:0] LEDG_ADDR = 32'h0000_7010;
    localparam logic [31:0] SW_ADDR   = 32'h0000_7800;
    localparam logic [26:0] HEX_PAGE  = 27'h381;  // 0x7020..0x703F

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] ledr_q;
    logic [31:0] ledg_q;
    logic [6:0]  hex_q [8];
    logic [31:0] sw_s1;
    logic [31:0] sw_s2;

    // address decode of the latched request
    logic [31:0]     off;
    logic [IDXW-1:0] dmem_idx;
    logic [2:0]      hex_sel;
    logic            is_dmem, is_ledr, is_ledg, is_hex, is_sw;
    logic            acc_err;
    logic            wr_ok;
    logic [31:0]     rd_c;
    logic            unused_bits;

    always_comb begin
        off      = addr_q - DMEM_BASE;
        dmem_idx = off[IDXW+1:2];
        hex_sel  = addr_q[4:2];
        is_dmem  = (addr_q >= DMEM_BASE) && (addr_q < DMEM_END);
        is_ledr  = (addr_q == LEDR_ADDR);
        is_ledg  = (addr_q == LEDG_ADDR);
        is_hex   = (addr_q[31:5] == HEX_PAGE);
        is_sw    = (addr_q == SW_ADDR);
        acc_err  = (addr_q[1:0] != 2'b00)
                 | ~(is_dmem | is_ledr | is_ledg | is_hex | is_sw)
                 | (we_q & is_sw);
        wr_ok    = (state == S_ACCESS) && we_q && !acc_err;
        rd_c     = '0;
        if (!acc_err && !we_q) begin
            if (is_dmem)      rd_c = dmem[dmem_idx];
            else if (is_ledr) rd_c = ledr_q;
            else if (is_ledg) rd_c = ledg_q;
            else if (is_hex)  rd_c = {25'd0, hex_q[hex_sel]};
            else if (is_sw)   rd_c = sw_s2;
        end
    end

    assign unused_bits = ^{off[31:IDXW+2], off[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q    <= bus.req_we_i;
                        addr_q  <= bus.req_addr_i;
                        wdata_q <= bus.req_wdata_i;
                        be_q    <= bus.req_be_i;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACCESS;
                        end else begin
                            cnt   <= 4'(WAIT_CYCLES - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_ACCESS;
                    else             cnt   <= cnt - 4'd1;
                end
                S_ACCESS: begin
                    rdata_q <= rd_c;
                    err_q   <= acc_err;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // data memory is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok && is_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) dmem[dmem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ledr_q <= '0;
            ledg_q <= '0;
            for (int n = 0; n < 8; n++) hex_q[n] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (is_ledr && be_q[b]) ledr_q[8*b +: 8] <= wdata_q[8*b +: 8];
                if (is_ledg && be_q[b]) ledg_q[8*b +: 8] <= wdata_q[8*b +: 8];
            end
            if (is_hex && be_q[0]) hex_q[hex_sel] <= wdata_q[6:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= io_sw_i;
            sw_s2 <= sw_s1;
        end
    end

    assign bus.req_ready_o = (state == S_IDLE);
    assign bus.rsp_valid_o = (state == S_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    assign io_ledr_o = ledr_q;
    assign io_ledg_o = ledg_q;
    assign io_hex0_o = hex_q[0];
    assign io_hex1_o = hex_q[1];
    assign io_hex2_o = hex_q[2];
    assign io_hex3_o = hex_q[3];
    assign io_hex4_o = hex_q[4];
    assign io_hex5_o = hex_q[5];
    assign io_hex6_o = hex_q[6];
    assign io_hex7_o = hex_q[7];
endmodule

// File: tb/tb_lsu_io_responder.sv
// Directed plus randomized bench for lsu_io_responder against an address-map model.
module tb_lsu_io_responder;
    localparam int DW = 512;
    localparam int WC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_io_if bus();
    logic [31:0] sw;
    logic [31:0] ledr, ledg;
    logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;

    lsu_io_responder #(.DMEM_WORDS(DW), .WAIT_CYCLES(WC)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .io_sw_i(sw),
        .io_ledr_o(ledr), .io_ledg_o(ledg),
        .io_hex0_o(h0), .io_hex1_o(h1), .io_hex2_o(h2), .io_hex3_o(h3),
        .io_hex4_o(h4), .io_hex5_o(h5), .io_hex6_o(h6), .io_hex7_o(h7)
    );

    int checks = 0;
    int failures = 0;

    // reference state
    logic [31:0] m_mem [int];
    logic [31:0] m_ledr, m_ledg, m_sw;
    logic [6:0]  m_hex [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [55:0] hex_obs();
        return {h7, h6, h5, h4, h3, h2, h1, h0};
    endfunction

    function automatic logic [55:0] hex_exp();
        return {m_hex[7], m_hex[6], m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    endfunction

    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic e);
        int i, n;
        rd = 0;
        e  = 0;
        if (a % 4 != 0) e = 1;
        else if (a >= 32'h2000 && a < 32'h2000 + 4 * DW) begin
            i = int'((a - 32'h2000) / 4);
            if (we) m_mem[i] = merge(m_mem.exists(i) ? m_mem[i] : 32'h0, wd, be);
            else    rd = m_mem[i];
        end else if (a == 32'h7000) begin
            if (we) m_ledr = merge(m_ledr, wd, be); else rd = m_ledr;
        end else if (a == 32'h7010) begin
            if (we) m_ledg = merge(m_ledg, wd, be); else rd = m_ledg;
        end else if (a >= 32'h7020 && a <= 32'h703C) begin
            n = int'((a - 32'h7020) / 4);
            if (we) begin
                if (be[0]) m_hex[n] = wd[6:0];
            end else rd = {25'd0, m_hex[n]};
        end else if (a == 32'h7800) begin
            if (we) e = 1; else rd = m_sw;
        end else e = 1;
    endtask

    task automatic run(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd_o, output logic er_o);
        logic [31:0] erd;
        logic        eer;
        int          lat;
        model(we, a, wd, be, erd, eer);
        @(posedge clk); #1;
        chk("req_ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i = 1;
        bus.req_we_i    = we;
        bus.req_addr_i  = a;
        bus.req_wdata_i = wd;
        bus.req_be_i    = be;
        bus.rsp_ready_i = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid_i = 0;
        bus.req_we_i    = 0;
        bus.req_wdata_i = $urandom;
        lat = 1;
        while (bus.rsp_valid_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 2 + WC);
        rd_o = bus.rsp_rdata_o;
        er_o = bus.rsp_err_o;
        chk("rdata", rd_o, erd);
        chk("err", er_o, eer);
        chk("ledr", ledr, m_ledr);
        chk("ledg", ledg, m_ledg);
        chk("hex", hex_obs(), hex_exp());
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.rsp_valid_o, 1);
            chk("hold_rdata", bus.rsp_rdata_o, erd);
            chk("hold_err", bus.rsp_err_o, eer);
            chk("hold_req_ready", bus.req_ready_o, 0);
        end
        bus.rsp_ready_i = 1;
        @(posedge clk); #1;
        chk("rsp_clear", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}, 0);
        chk("ready_back", bus.req_ready_o, 1);
    endtask

    int pool [9] = '{0, 1, 3, 7, 100, 255, 300, 510, 511};
    logic [31:0] unm [6] = '{32'h6000, 32'h0, 32'h7004, 32'h7040, 32'h7804, 32'h1FFC};

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic        we;
        int          kind;

        bus.req_valid_i = 0;
        bus.req_we_i    = 0;
        bus.req_addr_i  = 0;
        bus.req_wdata_i = 0;
        bus.req_be_i    = 0;
        bus.rsp_ready_i = 1;
        sw     = 0;
        m_sw   = 0;
        m_ledr = 0;
        m_ledg = 0;
        for (int n = 0; n < 8; n++) m_hex[n] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rdata", bus.rsp_rdata_o, 0);
        chk("rst_err", bus.rsp_err_o, 0);
        chk("rst_ledr", ledr, 0);
        chk("rst_ledg", ledg, 0);
        chk("rst_hex", hex_obs(), 0);
        rst = 0;

        for (int i = 0; i < 9; i++)
            run(1, 32'h2000 + 32'(4 * pool[i]), $urandom, 4'hF, 0, rd, er);

        // full-word store then load
        run(1, 32'h2004, 32'h1234_5678, 4'hF, 0, rd, er);
        run(0, 32'h2004, 0, 4'h0, 0, rd, er);
        chk("t1_rdata", rd, 32'h1234_5678);
        // partial byte-enable store
        run(1, 32'h2004, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
        run(0, 32'h2004, 0, 4'hF, 0, rd, er);
        chk("t2_rdata", rd, 32'h12BB_56DD);
        // be = 0 store is a legal no-op
        run(1, 32'h2004, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
        chk("be0_err", er, 0);
        // HEX3 keeps only bits [6:0]
        run(1, 32'h702C, 32'h0000_00FF, 4'hF, 0, rd, er);
        chk("t3_hex3", h3, 7'h7F);
        run(0, 32'h702C, 0, 4'h0, 0, rd, er);
        chk("t3_rdata", rd, 32'h0000_007F);
        // switches through the synchroniser; SW is read-only
        sw = 32'hDEAD_BEEF;
        m_sw = sw;
        repeat (3) @(posedge clk);
        run(0, 32'h7800, 0, 4'h0, 0, rd, er);
        chk("t4_rdata", rd, 32'hDEAD_BEEF);
        run(1, 32'h7800, 32'h0, 4'hF, 0, rd, er);
        chk("t4_store_err", er, 1);
        run(0, 32'h7800, 0, 4'h0, 0, rd, er);
        chk("t4_unchanged", rd, 32'hDEAD_BEEF);
        // fault cases
        run(0, 32'h2002, 0, 4'hF, 0, rd, er);
        chk("t5_misal_err", er, 1);
        run(0, 32'h6000, 0, 4'hF, 0, rd, er);
        chk("t5_unmap_err", er, 1);
        run(0, 32'h2000 + 4 * DW, 0, 4'hF, 0, rd, er);
        chk("t5_beyond_err", er, 1);
        run(1, 32'h2000 + 4 * DW, 32'h5555_AAAA, 4'hF, 0, rd, er);
        run(0, 32'h2000, 0, 4'hF, 0, rd, er);
        run(0, 32'h2004, 0, 4'hF, 0, rd, er);
        chk("t5_mem_kept", rd, 32'h12BB_56DD);
        // response held under back-pressure
        run(0, 32'h2004, 0, 4'hF, 5, rd, er);

        // reset while a LEDR store sits in WAIT
        @(posedge clk); #1;
        bus.req_valid_i = 1;
        bus.req_we_i    = 1;
        bus.req_addr_i  = 32'h7000;
        bus.req_wdata_i = 32'hFFFF_FFFF;
        bus.req_be_i    = 4'hF;
        @(posedge clk); #1;
        bus.req_valid_i = 0;
        bus.req_we_i    = 0;
        chk("mid_in_wait", bus.req_ready_o, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("mid_rst_ready", bus.req_ready_o, 1);
        chk("mid_rst_valid", bus.rsp_valid_o, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_ledr", ledr, 0);
        chk("mid_rst_hex", hex_obs(), 0);
        chk("mid_rst_idle", bus.req_ready_o, 1);
        m_ledr = 0;
        m_ledg = 0;
        for (int n = 0; n < 8; n++) m_hex[n] = 0;
        repeat (3) @(posedge clk);

        for (int it = 0; it < 120; it++) begin
            kind = int'($urandom_range(0, 8));
            we   = 1'($urandom);
            case (kind)
                0, 1: a = 32'h2000 + 32'(4 * pool[$urandom_range(0, 8)]);
                2:    a = 32'h7000;
                3:    a = 32'h7010;
                4:    a = 32'h7020 + 32'(4 * $urandom_range(0, 7));
                5: begin
                    a = 32'h7800;
                    if ($urandom_range(0, 1) == 1) begin
                        sw = $urandom;
                        m_sw = sw;
                        repeat (3) @(posedge clk);
                    end
                end
                6:    a = 32'h2000 + 32'(4 * pool[$urandom_range(0, 8)]) + 32'($urandom_range(1, 3));
                7:    a = unm[$urandom_range(0, 5)];
                default: a = 32'h2000 + 32'(4 * DW) + 32'(4 * $urandom_range(0, 15));
            endcase
            run(we, a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
